// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: N x N output-stationary signed MAC array with input skew and row-serial readout.
// Define SYSTOLIC_SAT_EN for saturating accumulation and the sticky sat flag.
module systolic_array_nxn #(
    parameter int DATA_WIDTH = 16,
    parameter int N = 4,
    parameter int ACC_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [N*DATA_WIDTH-1:0] a_col,
    input  logic [N*DATA_WIDTH-1:0] b_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*ACC_WIDTH-1:0]  out_data,
    output logic [$clog2(N)-1:0]    out_row,
    output logic                    out_last,
    output logic                    sat
);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(2 * N);
    localparam logic [RW-1:0] RLAST = RW'(N - 1);
    localparam logic [CW-1:0] CLAST = CW'(2 * N - 2);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] r;
    logic accept, clr;
    logic [N-1:0][DATA_WIDTH:0] sa_out, sb_out;
    logic [DATA_WIDTH:0] pa [N][N];
    logic [DATA_WIDTH:0] pb [N][N];
    logic signed [ACC_WIDTH-1:0] acc [N][N];

    assign in_ready  = state == IDLE || state == LOAD;
    assign out_valid = state == OUT;
    assign out_row   = r;
    assign out_last  = out_valid && r == RLAST;
    assign accept    = in_valid && in_ready;
    assign clr       = in_valid && state == IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            r     <= '0;
        end else begin
            case (state)
                IDLE, LOAD: if (accept) begin
                    state <= in_last ? DRAIN : LOAD;
                    cnt   <= '0;
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CLAST) begin
                        state <= OUT;
                        r     <= '0;
                    end
                end
                OUT: if (out_ready) begin
                    r <= r == RLAST ? '0 : r + 1'b1;
                    if (r == RLAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane i of both operands is delayed i cycles so wavefronts meet at PE(i,j) together.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_WIDTH:0] ia, ib;
        assign ia = {accept, a_col[i*DATA_WIDTH +: DATA_WIDTH]};
        assign ib = {accept, b_row[i*DATA_WIDTH +: DATA_WIDTH]};
        if (i == 0) begin : g_d0
            assign sa_out[0] = ia;
            assign sb_out[0] = ib;
        end else begin : g_dn
            logic [DATA_WIDTH:0] da [i];
            logic [DATA_WIDTH:0] db [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) begin
                        da[s] <= '0;
                        db[s] <= '0;
                    end
                end else begin
                    da[0] <= ia;
                    db[0] <= ib;
                    for (int s = 1; s < i; s++) begin
                        da[s] <= clr ? '0 : da[s-1];
                        db[s] <= clr ? '0 : db[s-1];
                    end
                end
            end
            assign sa_out[i] = da[i-1];
            assign sb_out[i] = db[i-1];
        end
        assign out_data[i*ACC_WIDTH +: ACC_WIDTH] = acc[r][i];
    end

`ifdef SYSTOLIC_SAT_EN
    logic [N*N-1:0] clip;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sat <= 1'b0;
        else if (clr) sat <= 1'b0;
        else if (|clip) sat <= 1'b1;
    end
`else
    assign sat = 1'b0;
`endif

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_pe
            localparam bit HEAD = i == 0 && j == 0;
            logic [DATA_WIDTH:0] a_in, b_in;
            logic signed [2*DATA_WIDTH-1:0] prod;
            logic signed [ACC_WIDTH-1:0] pe, nxt;
            logic v;
            if (j == 0) begin : g_al
                assign a_in = sa_out[i];
            end else begin : g_ai
                assign a_in = pa[i][j-1];
            end
            if (i == 0) begin : g_bt
                assign b_in = sb_out[j];
            end else begin : g_bi
                assign b_in = pb[i-1][j];
            end
            assign v    = pa[i][j][DATA_WIDTH] && pb[i][j][DATA_WIDTH];
            assign prod = (2*DATA_WIDTH)'($signed(pa[i][j][DATA_WIDTH-1:0]))
                        * (2*DATA_WIDTH)'($signed(pb[i][j][DATA_WIDTH-1:0]));
            assign pe   = ACC_WIDTH'(prod);
`ifdef SYSTOLIC_SAT_EN
            logic [ACC_WIDTH:0] sm;
            assign sm = {acc[i][j][ACC_WIDTH-1], acc[i][j]} + {pe[ACC_WIDTH-1], pe};
            assign clip[i*N+j] = v && (sm[ACC_WIDTH] != sm[ACC_WIDTH-1]);
            assign nxt = (sm[ACC_WIDTH] != sm[ACC_WIDTH-1])
                       ? {sm[ACC_WIDTH], {(ACC_WIDTH-1){~sm[ACC_WIDTH]}}} : sm[ACC_WIDTH-1:0];
`else
            assign nxt = acc[i][j] + pe;
`endif
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pa[i][j]  <= (clr && !HEAD) ? '0 : a_in;
                    pb[i][j]  <= (clr && !HEAD) ? '0 : b_in;
                    acc[i][j] <= clr ? '0 : v ? nxt : acc[i][j];
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb_systolic_array_nxn: directed self-checking bench for the 4x4 default configuration.
module tb_systolic_array_nxn;
    localparam int DW = 16;
    localparam int N = 4;
    localparam int AW = 32;

    logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [N*DW-1:0] a_col = '0, b_row = '0;
    logic in_ready, out_valid, out_last, sat;
    logic [N*AW-1:0] out_data;
    logic [1:0] out_row;

    systolic_array_nxn #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_last(out_last), .sat(sat)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    int am [N][N];
    int bm [N][N];
    int ex [N][N];
    int got [N][N];
    int got_row [N];
    logic got_last [N];
    logic got_v [N];
    int lat;
    logic timeout, stable, rdy_after, rdy_out, sat_seen;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int kb, input int bub_after, input int nbub);
        for (int k = 0; k < kb; k++) begin
            for (int i = 0; i < N; i++) begin
                a_col[i*DW +: DW] = 16'(am[i][k]);
                b_row[i*DW +: DW] = 16'(bm[k][i]);
            end
            in_valid = 1'b1;
            in_last  = (k == kb - 1);
            step;
            if (k == bub_after) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                repeat (nbub) step;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic capture(input int hold_row, input int hold_n);
        logic [N*AW-1:0] sd;
        logic [1:0] sr;
        timeout = 1'b0;
        stable = 1'b1;
        lat = 0;
        out_ready = 1'b1;
        while (!out_valid && lat < 100) begin
            step;
            lat++;
        end
        if (!out_valid) timeout = 1'b1;
        rdy_out = in_ready;
        for (int r = 0; r < N; r++) begin
            if (r == hold_row) begin
                out_ready = 1'b0;
                sd = out_data;
                sr = out_row;
                for (int h = 0; h < hold_n; h++) begin
                    step;
                    if (out_data !== sd || out_row !== sr || out_valid !== 1'b1) stable = 1'b0;
                end
                out_ready = 1'b1;
            end
            got_v[r] = out_valid;
            got_row[r] = int'(out_row);
            got_last[r] = out_last;
            sat_seen = sat;
            for (int j = 0; j < N; j++) got[r][j] = int'($signed(out_data[j*AW +: AW]));
            step;
        end
        rdy_after = in_ready;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if ({out_row, out_last, sat} !== 4'b0) begin fails++; $display("FAIL reset_row_last_sat: got %b want 0000", {out_row, out_last, sat}); end
        repeat (2) step;
        rst = 1'b1;
        step;
    endtask

    task automatic test_ones(input string tag);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                am[i][k] = 1; bm[i][k] = 1; ex[i][k] = 4;
            end
        send(4, -1, 0);
        capture(-1, 0);
        checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL %s_timeout: out_valid never rose", tag); end
        checks++; if (lat !== 7) begin fails++; $display("FAIL %s_latency: got %0d want 7", tag, lat); end
        checks++; if (rdy_out !== 1'b0) begin fails++; $display("FAIL %s_in_ready_out: got %b want 0", tag, rdy_out); end
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_v[r] !== 1'b1 || got_row[r] !== r || got_last[r] !== (r == N - 1)) begin
                fails++; $display("FAIL %s_row%0d_ctl: valid %b row %0d last %b want 1 %0d %b", tag, r, got_v[r], got_row[r], got_last[r], r, r == N - 1);
            end
            for (int j = 0; j < N; j++) begin
                checks++; if (got[r][j] !== ex[r][j]) begin fails++; $display("FAIL %s_c%0d%0d: got %0d want %0d", tag, r, j, got[r][j], ex[r][j]); end
            end
        end
        checks++; if (rdy_after !== 1'b1) begin fails++; $display("FAIL %s_in_ready_after: got %b want 1", tag, rdy_after); end
    endtask

    task automatic test_bubbles;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                am[i][k] = 4 * i + k + 1; bm[i][k] = (i == k) ? 1 : 0; ex[i][k] = 4 * i + k + 1;
            end
        send(4, 1, 2);
        capture(-1, 0);
        checks++; if (lat !== 7) begin fails++; $display("FAIL bub_latency: got %0d want 7", lat); end
        for (int r = 0; r < N; r++) begin
            checks++; if (got_row[r] !== r) begin fails++; $display("FAIL bub_row%0d: got %0d want %0d", r, got_row[r], r); end
            for (int j = 0; j < N; j++) begin
                checks++; if (got[r][j] !== ex[r][j]) begin fails++; $display("FAIL bub_c%0d%0d: got %0d want %0d", r, j, got[r][j], ex[r][j]); end
            end
        end
    endtask

    task automatic test_k1;
        int av [N];
        int bv [N];
        av = '{2, 3, 4, 5};
        bv = '{1, -1, 2, -2};
        for (int i = 0; i < N; i++) begin
            am[i][0] = av[i]; bm[0][i] = bv[i];
            for (int j = 0; j < N; j++) ex[i][j] = av[i] * bv[j];
        end
        send(1, -1, 0);
        capture(-1, 0);
        checks++; if (lat !== 7) begin fails++; $display("FAIL k1_latency: got %0d want 7", lat); end
        checks++; if (got[3][3] !== -10) begin fails++; $display("FAIL k1_c33: got %0d want -10", got[3][3]); end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) begin
                checks++; if (got[r][j] !== ex[r][j]) begin fails++; $display("FAIL k1_c%0d%0d: got %0d want %0d", r, j, got[r][j], ex[r][j]); end
            end
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                am[i][k] = 4 * i + k + 1; bm[i][k] = (i == k) ? 1 : 0; ex[i][k] = 4 * i + k + 1;
            end
        send(4, -1, 0);
        capture(1, 3);
        checks++; if (stable !== 1'b1) begin fails++; $display("FAIL bp_stable: got %b want 1", stable); end
        checks++; if (rdy_after !== 1'b1) begin fails++; $display("FAIL bp_in_ready_after: got %b want 1", rdy_after); end
        for (int r = 0; r < N; r++) begin
            checks++; if (got_row[r] !== r || got_last[r] !== (r == N - 1)) begin fails++; $display("FAIL bp_row%0d: row %0d last %b want %0d %b", r, got_row[r], got_last[r], r, r == N - 1); end
            checks++; if (got[r][r] !== ex[r][r]) begin fails++; $display("FAIL bp_c%0d%0d: got %0d want %0d", r, r, got[r][r], ex[r][r]); end
        end
    endtask

    task automatic test_sat;
        int e00;
        logic es;
`ifdef SYSTOLIC_SAT_EN
        e00 = 32'h7FFFFFFF; es = 1'b1;
`else
        e00 = -1073938429; es = 1'b0;
`endif
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                am[i][k] = (i == 0 && k < 3) ? 32767 : 0;
                bm[k][i] = (i == 0 && k < 3) ? 32767 : 0;
            end
        send(3, -1, 0);
        capture(-1, 0);
        checks++; if (got[0][0] !== e00) begin fails++; $display("FAIL sat_c00: got %0d want %0d", got[0][0], e00); end
        checks++; if (sat_seen !== es) begin fails++; $display("FAIL sat_flag: got %b want %b", sat_seen, es); end
        checks++; if (got[1][1] !== 0) begin fails++; $display("FAIL sat_c11: got %0d want 0", got[1][1]); end
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                am[i][k] = 1; bm[i][k] = 1;
            end
        send(4, -1, 0);
        step;
        step;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL mr_handshake: in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
        checks++; if (out_data !== '0) begin fails++; $display("FAIL mr_out_data: got %h want 0", out_data); end
        checks++; if ({out_row, out_last, sat} !== 4'b0) begin fails++; $display("FAIL mr_row_last_sat: got %b want 0000", {out_row, out_last, sat}); end
        step;
        rst = 1'b1;
        step;
        test_ones("mr_ones");
    endtask

    initial begin
        test_reset;
        test_ones("ones");
        test_bubbles;
        test_k1;
        test_backpressure;
        test_sat;
        test_mid_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/systolic_array_nxn.md
# systolic_array_nxn

Parametrised output-stationary N×N signed MAC systolic array with built-in input skew, valid/ready input streaming and row-serial result readout. Next generation of the fixed 4×4 array: it takes K beats of A columns / B rows, computes C = A·B with K unbounded, and streams C out one row per handshake. No external `result_ld` pulse. Sits between the operand buffers and the result writeback path.

## Interface
- `DATA_WIDTH`, 16: signed operand width.
- `N`, 4: array dimension, ≥2.
- `ACC_WIDTH`, 2*DATA_WIDTH: signed accumulator width, ≥2*DATA_WIDTH.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  array accepts beats.
- `in_last`  in  1  final beat (k = K-1) of the current product.
- `a_col`  in  N*DATA_WIDTH  A[i][k]; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- `b_row`  in  N*DATA_WIDTH  B[k][j]; lane j.
- `out_valid`  out  1  result row valid.
- `out_ready`  in  1  downstream accepts row.
- `out_data`  out  N*ACC_WIDTH  C[r][j]; lane j.
- `out_row`  out  $clog2(N)  row index r.
- `out_last`  out  1  high with row N-1.
- `sat`  out  1  sticky per-product saturation flag.

## Operation
- FSM states: IDLE, LOAD, DRAIN, OUT.
  - IDLE: `in_ready`=1. An accepted beat clears all accumulators and skew/valid pipes, then moves to LOAD (or to DRAIN if `in_last`).
  - LOAD: `in_ready`=1. Accepted beat with `in_last` moves to DRAIN.
  - DRAIN: `in_ready`=0. Counter runs 2N-1 cycles, then moves to OUT with r=0.
  - OUT: `in_ready`=0. Each `out_valid && out_ready` increments r. The handshake at r=N-1 moves to IDLE.
- Skew: lane i of `a_col` and lane j of `b_row` are delayed i and j registers respectively. Each value travels with its own valid bit.
- PE(i,j):
  - Registers a rightward and b downward with valid.
  - On valid, acc += a·b. Full signed product is 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH.
- Bubbles: cycles with `in_valid`=0 in LOAD inject valid=0. No MAC occurs; the result is unaffected.
- K=1: `in_last` on the first beat is legal.
- `out_data`, `out_row`, `out_last` come straight from accumulator row r and are held stable while `out_valid && !out_ready`.
- Mid-operation reset: every register clears immediately and the FSM returns to IDLE. The partial product is discarded.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_row`=0, `out_last`=0, `sat`=0.
  - All accumulators, skew and valid pipes are 0.
- A beat accepted on edge E updates PE(i,j) on edge E+1+i+j.
- Last beat accepted on edge EL:
  - Final MAC at PE(N-1,N-1) on edge EL+2N-1.
  - `out_valid` is high in the cycle after that edge, i.e. 2N-1 cycles after EL.
- Throughput: 1 beat/cycle in LOAD. Readout takes N cycles minimum.
- `in_ready` falls in the cycle after the `in_last` handshake. It rises in the cycle after the final output handshake.
- `out_ready` may be high before `out_valid`; no handshake occurs until `out_valid` is high.

## Configuration
- `SYSTOLIC_SAT_EN` defined:
  - Accumulation saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clipped MAC sets `sat`. `sat` holds through OUT and clears on the first beat of the next product.
- Not defined: accumulation wraps modulo 2^ACC_WIDTH and `sat` is tied to 0.

## Test plan
- N=4, A all 1s, B all 1s, K=4 (4 back-to-back beats, `out_ready`=1):
  - Rows 0..3 each have all lanes = 4.
  - `out_valid` rises 7 cycles after the last-beat edge.
  - `out_last` only with `out_row`=3.
- N=4, B=identity, A = [[1..4],[5..8],[9..12],[13..16]] with 2 bubble cycles inserted mid-stream -> C equals A row by row.
- K=1 beat with `in_last`=1, a=(2,3,4,5), b=(1,-1,2,-2) -> C[i][j]=a_i·b_j, e.g. C[3][3]=-10.
- `out_ready` low for 3 cycles on row 1 -> `out_data` and `out_row`=1 held stable; row sequence 0,1,2,3 is unbroken; `in_ready` returns 1 after the row 3 handshake.
- K=3, A[0][k]=B[k][0]=32767, ACC_WIDTH=32:
  - With `SYSTOLIC_SAT_EN`: C[0][0]=0x7FFFFFFF and `sat`=1.
  - Without it: C[0][0]=-1073938429 and `sat`=0.
- Assert `rst`=0 during DRAIN -> all outputs at reset values the same cycle; a following K=4 all-ones product yields all 4s (no residue).
